// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the CPU control blocks.
//   - COND_EQ..COND_NV : 4-bit branch condition codes
//   - FLAG_Z/C/N/V     : bit positions inside the 4-bit flags word {Z,C,N,V}
//   - pack_flags()     : builds a flags word from the individual ALU flags
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  // Places the individual ALU flags at their architectural bit positions.
  function automatic logic [3:0] pack_flags(input logic z, input logic c,
                                            input logic n, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/flag_unit_if.sv
// ---------------------------------------------------------------------------
// flag_unit_if
// Bundles everything exchanged between the flag unit and the CPU core.
//   master : drives ALU flags, condition requests and stack push/pop
//   slave  : the flag unit; returns take/take_valid, flags, stack status
// Parameter CNT_W : width of the stack depth counter.
// ---------------------------------------------------------------------------
interface flag_unit_if #(parameter int CNT_W = 5);

  logic             flags_we;
  logic             fz_in;
  logic             fc_in;
  logic             fn_in;
  logic             fv_in;
  logic [3:0]       cond;
  logic             cond_valid;
  logic             push;
  logic             pop;
  logic             take;
  logic             take_valid;
  logic [3:0]       flags;
  logic [CNT_W-1:0] depth;
  logic             stk_full;
  logic             stk_empty;
  logic             stk_err;

  modport master (
    output flags_we, fz_in, fc_in, fn_in, fv_in, cond, cond_valid, push, pop,
    input  take, take_valid, flags, depth, stk_full, stk_empty, stk_err
  );

  modport slave (
    input  flags_we, fz_in, fc_in, fn_in, fv_in, cond, cond_valid, push, pop,
    output take, take_valid, flags, depth, stk_full, stk_empty, stk_err
  );

endinterface

// File: rtl/flag_unit_cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Purely combinational branch-condition evaluator.
//   cond   (in, 4)  : condition code COND_EQ..COND_NV
//   flags  (in, 4)  : flags word {Z,C,N,V}
//   result (out, 1) : 1 when the condition holds
// ---------------------------------------------------------------------------
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       result
);

  logic z, c, n, v;

  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];

  // C is a borrow after SUB, so "unsigned higher" needs C clear as well as Z.
  always_comb begin
    result = 1'b0;
    case (cond)
      COND_EQ: result = z;
      COND_NE: result = ~z;
      COND_CS: result = c;
      COND_CC: result = ~c;
      COND_MI: result = n;
      COND_PL: result = ~n;
      COND_VS: result = v;
      COND_VC: result = ~v;
      COND_HI: result = ~c & ~z;
      COND_LS: result = c | z;
      COND_GE: result = ~(n ^ v);
      COND_LT: result = n ^ v;
      COND_GT: result = ~z & ~(n ^ v);
      COND_LE: result = z | (n ^ v);
      COND_AL: result = 1'b1;
      COND_NV: result = 1'b0;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_unit.sv
// ---------------------------------------------------------------------------
// flag_unit
// Architectural Z/C/N/V flags register, registered branch-condition
// evaluation and a small LIFO flag-save stack for interrupt entry/return.
//   clk  (in)        : clock, all state changes on the rising edge
//   rst  (in)        : synchronous active-high reset, beats every other input
//   bus  (slave)     : flags_we, fz/fc/fn/fv_in, cond, cond_valid, push, pop in;
//                      take, take_valid, flags, depth, stk_full, stk_empty,
//                      stk_err out
// Parameters: STACK_DEPTH (2..16) save entries, CNT_W depth counter width.
// Build option: define FLAG_FWD_EN to evaluate a condition against the ALU
// flags being written in the same cycle (never against a popped value).
// ---------------------------------------------------------------------------
module flag_unit
  import cpu_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int CNT_W       = 5
)(
  input logic        clk,
  input logic        rst,
  flag_unit_if.slave bus
);

  localparam int IDX_W = $clog2(STACK_DEPTH);

  logic [3:0]       flags_q;
  logic [3:0]       alu_flags;
  logic [3:0]       eval_flags;
  logic [3:0]       top_entry;
  logic [CNT_W-1:0] depth_q;
  logic [CNT_W-1:0] depth_m1;
  logic [3:0]       stack_mem [STACK_DEPTH];
  logic             full;
  logic             empty;
  logic             push_ok;
  logic             pop_ok;
  logic             err_set;
  logic             cond_result;
  logic             take_q;
  logic             take_valid_q;
  logic             err_q;

  assign alu_flags = pack_flags(bus.fz_in, bus.fc_in, bus.fn_in, bus.fv_in);
  assign full      = (depth_q == CNT_W'(STACK_DEPTH));
  assign empty     = (depth_q == '0);
  assign depth_m1  = depth_q - CNT_W'(1);
  assign top_entry = stack_mem[depth_m1[IDX_W-1:0]];

  // A simultaneous push and pop is treated as a programming error and
  // neither operation takes effect.
  assign push_ok = bus.push & ~bus.pop & ~full;
  assign pop_ok  = bus.pop & ~bus.push & ~empty;
  assign err_set = (bus.push & bus.pop) | (bus.push & full) | (bus.pop & empty);

`ifdef FLAG_FWD_EN
  assign eval_flags = (bus.flags_we & ~bus.pop) ? alu_flags : flags_q;
`else
  assign eval_flags = flags_q;
`endif

  cond_eval u_cond_eval (
    .cond   (bus.cond),
    .flags  (eval_flags),
    .result (cond_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q      <= 4'b0000;
      depth_q      <= '0;
      err_q        <= 1'b0;
      take_q       <= 1'b0;
      take_valid_q <= 1'b0;
    end else begin
      if (pop_ok) begin
        flags_q <= top_entry;
      end else if (bus.flags_we) begin
        flags_q <= alu_flags;
      end
      if (push_ok) begin
        depth_q <= depth_q + CNT_W'(1);
      end else if (pop_ok) begin
        depth_q <= depth_m1;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
      take_valid_q <= bus.cond_valid;
      if (bus.cond_valid) begin
        take_q <= cond_result;
      end
    end
  end

  // Stack storage has no reset; a push saves the pre-edge flags so a
  // same-cycle flags_we makes the new value live while the old one is kept.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      stack_mem[depth_q[IDX_W-1:0]] <= flags_q;
    end
  end

  assign bus.flags      = flags_q;
  assign bus.depth      = depth_q;
  assign bus.stk_full   = full;
  assign bus.stk_empty  = empty;
  assign bus.stk_err    = err_q;
  assign bus.take       = take_q;
  assign bus.take_valid = take_valid_q;

endmodule

// File: tb/tb_flag_unit.sv
// ---------------------------------------------------------------------------
// tb_flag_unit
// Directed bench for flag_unit with a behavioural reference model (queue
// based stack, table-driven condition predicates) checked every cycle, plus
// literal expectations at the interesting points of each scenario.
// Honours FLAG_FWD_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_flag_unit;
  import cpu_pkg::*;

  localparam int STACK_DEPTH = 4;
  localparam int CNT_W       = 5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  flag_unit_if #(.CNT_W(CNT_W)) bus ();

  flag_unit #(.STACK_DEPTH(STACK_DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] m_flags;
  logic [3:0] m_stack [$];
  logic       m_take;
  logic       m_tv;
  logic       m_err;
  bit         m_live = 0;

  // Even codes are a base predicate, odd codes its negation:
  // 0 Z, 2 C, 4 N, 6 V, 8 unsigned-higher, 10 signed-ge, 12 signed-gt, 14 always.
  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
    logic       z, cf, n, v;
    logic [7:0] pred;
    logic [2:0] sel;
    z    = f[3];
    cf   = f[2];
    n    = f[1];
    v    = f[0];
    pred = {1'b1, (!z && (n == v)), (n == v), (!cf && !z), v, n, cf, z};
    sel  = c[3:1];
    return c[0] ? !pred[sel] : pred[sel];
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic we, input logic [3:0] f,
                               input logic [3:0] c, input logic cv,
                               input logic pu, input logic po);
    rst            = r;
    bus.flags_we   = we;
    bus.fz_in      = f[3];
    bus.fc_in      = f[2];
    bus.fn_in      = f[1];
    bus.fv_in      = f[0];
    bus.cond       = c;
    bus.cond_valid = cv;
    bus.push       = pu;
    bus.pop        = po;
    @(negedge clk);
  endtask

  // Reference model: advances on every rising edge from the applied inputs.
  always @(posedge clk) begin
    logic [3:0] old_f;
    logic [3:0] alu_f;
    logic [3:0] eval_f;
    logic [3:0] popped;
    bit         pop_done;
    if (rst) begin
      m_flags = 4'h0;
      m_stack.delete();
      m_take  = 1'b0;
      m_tv    = 1'b0;
      m_err   = 1'b0;
      m_live  = 1;
    end else if (m_live) begin
      old_f    = m_flags;
      alu_f    = {bus.fz_in, bus.fc_in, bus.fn_in, bus.fv_in};
      eval_f   = old_f;
`ifdef FLAG_FWD_EN
      if (bus.flags_we && !bus.pop) eval_f = alu_f;
`endif
      if (bus.cond_valid) m_take = model_cond(bus.cond, eval_f);
      m_tv     = bus.cond_valid;
      pop_done = 0;
      popped   = 4'h0;
      if (bus.push && bus.pop) begin
        m_err = 1'b1;
      end else if (bus.push) begin
        if (m_stack.size() == STACK_DEPTH) m_err = 1'b1;
        else m_stack.push_back(old_f);
      end else if (bus.pop) begin
        if (m_stack.size() == 0) begin
          m_err = 1'b1;
        end else begin
          popped   = m_stack.pop_back();
          pop_done = 1;
        end
      end
      if (pop_done) m_flags = popped;
      else if (bus.flags_we) m_flags = alu_f;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (m_live) begin
      checkOutput("flags", 8'(bus.flags), 8'(m_flags));
      checkOutput("depth", 8'(bus.depth), 8'(m_stack.size()));
      checkOutput("stk_full", 8'(bus.stk_full), 8'(m_stack.size() == STACK_DEPTH));
      checkOutput("stk_empty", 8'(bus.stk_empty), 8'(m_stack.size() == 0));
      checkOutput("stk_err", 8'(bus.stk_err), 8'(m_err));
      checkOutput("take_valid", 8'(bus.take_valid), 8'(m_tv));
      checkOutput("take", 8'(bus.take), 8'(m_take));
    end
  end

  initial begin
    logic [3:0] sweep [6];
    sweep = '{4'h0, 4'h5, 4'hA, 4'hF, 4'h6, 4'h9};

    // Reset state
    applyStimulus(1, 0, 4'h0, 4'h0, 0, 0, 0);
    checkOutput("rst_flags", 8'(bus.flags), 8'h0);
    checkOutput("rst_depth", 8'(bus.depth), 8'h0);
    checkOutput("rst_empty", 8'(bus.stk_empty), 8'h1);
    checkOutput("rst_full", 8'(bus.stk_full), 8'h0);
    checkOutput("rst_err", 8'(bus.stk_err), 8'h0);
    checkOutput("rst_tv", 8'(bus.take_valid), 8'h0);

    // Z=1: EQ taken, NE not
    applyStimulus(0, 1, 4'h8, 4'h0, 0, 0, 0);
    checkOutput("z_flags", 8'(bus.flags), 8'h8);
    applyStimulus(0, 0, 4'h0, COND_EQ, 1, 0, 0);
    checkOutput("eq_take", 8'(bus.take), 8'h1);
    checkOutput("eq_tv", 8'(bus.take_valid), 8'h1);
    applyStimulus(0, 0, 4'h0, COND_NE, 1, 0, 0);
    checkOutput("ne_take", 8'(bus.take), 8'h0);
    applyStimulus(0, 0, 4'h0, COND_AL, 0, 0, 0);
    checkOutput("idle_tv", 8'(bus.take_valid), 8'h0);
    checkOutput("idle_take_hold", 8'(bus.take), 8'h0);

    // 0x0001 - 0x0002: Z=0 C=1 N=1 V=0
    applyStimulus(0, 1, 4'h6, 4'h0, 0, 0, 0);
    applyStimulus(0, 0, 4'h0, COND_LS, 1, 0, 0);
    checkOutput("ls_take", 8'(bus.take), 8'h1);
    applyStimulus(0, 0, 4'h0, COND_HI, 1, 0, 0);
    checkOutput("hi_take", 8'(bus.take), 8'h0);
    applyStimulus(0, 0, 4'h0, COND_LT, 1, 0, 0);
    checkOutput("lt_take", 8'(bus.take), 8'h1);
    applyStimulus(0, 0, 4'h0, COND_GE, 1, 0, 0);
    checkOutput("ge_take", 8'(bus.take), 8'h0);

    // All sixteen codes against a spread of flag values (model-checked)
    foreach (sweep[i]) begin
      applyStimulus(0, 1, sweep[i], 4'h0, 0, 0, 0);
      for (int c = 0; c < 16; c++) applyStimulus(0, 0, 4'h0, 4'(c), 1, 0, 0);
    end

    // Fill the stack, overflow, then drain in LIFO order
    applyStimulus(1, 0, 4'h0, 4'h0, 0, 0, 0);
    applyStimulus(0, 1, 4'h1, 4'h0, 0, 0, 0);
    applyStimulus(0, 1, 4'h2, 4'h0, 0, 1, 0);
    checkOutput("push_live_flags", 8'(bus.flags), 8'h2);
    applyStimulus(0, 1, 4'h4, 4'h0, 0, 1, 0);
    applyStimulus(0, 1, 4'h8, 4'h0, 0, 1, 0);
    applyStimulus(0, 0, 4'h0, 4'h0, 0, 1, 0);
    checkOutput("full_depth", 8'(bus.depth), 8'h4);
    checkOutput("full_flag", 8'(bus.stk_full), 8'h1);
    checkOutput("full_no_err", 8'(bus.stk_err), 8'h0);
    applyStimulus(0, 0, 4'h0, 4'h0, 0, 1, 0);
    checkOutput("ovf_depth", 8'(bus.depth), 8'h4);
    checkOutput("ovf_err", 8'(bus.stk_err), 8'h1);
    applyStimulus(0, 0, 4'h0, 4'h0, 0, 0, 1);
    checkOutput("pop1", 8'(bus.flags), 8'h8);
    applyStimulus(0, 0, 4'h0, 4'h0, 0, 0, 1);
    checkOutput("pop2", 8'(bus.flags), 8'h4);
    applyStimulus(0, 1, 4'hF, 4'h0, 0, 0, 1);
    checkOutput("pop3_beats_we", 8'(bus.flags), 8'h2);
    applyStimulus(0, 0, 4'h0, 4'h0, 0, 0, 1);
    checkOutput("pop4", 8'(bus.flags), 8'h1);
    checkOutput("drained_empty", 8'(bus.stk_empty), 8'h1);

    // Pop on empty stack with flags_we: ALU flags still land
    applyStimulus(1, 0, 4'h0, 4'h0, 0, 0, 0);
    applyStimulus(0, 1, 4'hA, 4'h0, 0, 0, 1);
    checkOutput("uflow_flags", 8'(bus.flags), 8'hA);
    checkOutput("uflow_depth", 8'(bus.depth), 8'h0);
    checkOutput("uflow_err", 8'(bus.stk_err), 8'h1);

    // push+pop together at depth 2, then reset clears everything
    applyStimulus(1, 0, 4'h0, 4'h0, 0, 0, 0);
    applyStimulus(0, 1, 4'h3, 4'h0, 0, 0, 0);
    applyStimulus(0, 1, 4'h5, 4'h0, 0, 1, 0);
    applyStimulus(0, 0, 4'h0, 4'h0, 0, 1, 0);
    applyStimulus(0, 0, 4'h0, 4'h0, 0, 1, 1);
    checkOutput("pp_depth", 8'(bus.depth), 8'h2);
    checkOutput("pp_flags", 8'(bus.flags), 8'h5);
    checkOutput("pp_err", 8'(bus.stk_err), 8'h1);
    applyStimulus(1, 1, 4'hF, 4'h0, 1, 1, 0);
    checkOutput("rst2_err", 8'(bus.stk_err), 8'h0);
    checkOutput("rst2_depth", 8'(bus.depth), 8'h0);
    checkOutput("rst2_flags", 8'(bus.flags), 8'h0);

    // Same-cycle flags_we and EQ evaluation
    applyStimulus(0, 1, 4'h8, COND_EQ, 1, 0, 0);
`ifdef FLAG_FWD_EN
    checkOutput("fwd_eq_take", 8'(bus.take), 8'h1);
`else
    checkOutput("fwd_eq_take", 8'(bus.take), 8'h0);
`endif
    checkOutput("fwd_flags", 8'(bus.flags), 8'h8);
    // Pop never forwards: evaluation sees the current register (Z=1)
    applyStimulus(0, 0, 4'h0, 4'h0, 0, 1, 0);
    applyStimulus(0, 1, 4'h0, COND_EQ, 1, 0, 1);
    checkOutput("pop_nofwd_take", 8'(bus.take), 8'h1);
    checkOutput("pop_nofwd_flags", 8'(bus.flags), 8'h8);

    applyStimulus(0, 0, 4'h0, 4'h0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Status-flag consumer for the 16-bit CPU datapath. It latches the ALU's Z/C/N/V outputs into an architectural flags register and evaluates 4-bit branch condition codes against that register.
- It also provides a small save/restore stack so flags survive interrupt entry and return.
- Sits between the ALU flag outputs and the control unit's branch/interrupt logic.

Parameters:
- STACK_DEPTH, 4, number of flag-save entries; legal range 2..16.
- CNT_W, 5, width of the depth counter; must satisfy 2^CNT_W > STACK_DEPTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flags_we  input  1  latch fz_in/fc_in/fn_in/fv_in into the flags register.
- fz_in  input  1  ALU zero flag.
- fc_in  input  1  ALU carry flag. After SUB this is the borrow: 1 when a < b unsigned.
- fn_in  input  1  ALU negative flag.
- fv_in  input  1  ALU overflow flag.
- cond  input  4  condition code to evaluate.
- cond_valid  input  1  request evaluation of cond.
- take  output  1  registered condition result.
- take_valid  output  1  registered; high one cycle after cond_valid.
- push  input  1  save current flags onto the stack.
- pop  input  1  restore flags from the top of the stack.
- flags  output  4  architectural flags, bit order {Z,C,N,V} (bit3 = Z).
- depth  output  CNT_W  number of occupied stack entries.
- stk_full  output  1  depth == STACK_DEPTH.
- stk_empty  output  1  depth == 0.
- stk_err  output  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset: flags=0, take=0, take_valid=0, depth=0, stk_err=0, stk_empty=1, stk_full=0. Stack contents are don't-care.
- Reset mid-operation: rst has priority over every other input in that cycle. Stack contents are abandoned.
- Flags register update, in priority order:
  - pop (legal): flags <= top entry.
  - else flags_we: flags <= {fz_in,fc_in,fn_in,fv_in}.
  - else hold.
- push (legal): stores the flags value from before this edge, depth+1. flags_we in the same cycle still updates flags, so the old value is saved and the new value is live.
- pop with flags_we in the same cycle: pop wins; the ALU flags are discarded.
- push and pop in the same cycle: both ignored, stk_err <= 1.
- push when stk_full: ignored, depth unchanged, stk_err <= 1.
- pop when stk_empty: ignored, flags unchanged (flags_we may still apply), stk_err <= 1.
- Stack is LIFO with no wrap-around. depth stays in 0..STACK_DEPTH.
- Condition evaluation:
  - Latency 1: take and take_valid are registered from cond and cond_valid.
  - Evaluated against the flags register value before the edge. A same-cycle flags_we or pop is not seen.
  - take_valid=0 whenever cond_valid=0 in the previous cycle; take holds its last value.
- Condition codes (Z,C,N,V = flags register):
  - 0 EQ Z; 1 NE !Z
  - 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N
  - 6 VS V; 7 VC !V
  - 8 HI !C&!Z (unsigned greater after SUB); 9 LS C|Z
  - 10 GE N==V; 11 LT N!=V
  - 12 GT !Z&(N==V); 13 LE Z|(N!=V)
  - 14 AL 1; 15 NV 0

Optional Feature:
- Macro: FLAG_FWD_EN.
- Defined: when flags_we=1 and pop=0 in the same cycle as cond_valid, the condition is evaluated against {fz_in,fc_in,fn_in,fv_in} instead of the register. This allows compare-and-branch in back-to-back cycles. pop never forwards.
- Undefined: the condition always uses the registered flags, as described in Behaviour.

Decomposition:
- Shared package cpu_pkg holds:
  - the condition-code constants COND_EQ..COND_NV (4-bit);
  - flag bit indices FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_V=0.
- Sub-module cond_eval: purely combinational, maps (cond, 4-bit flags) to a 1-bit result.
- The flag register, stack and depth counter stay in flag_unit.

Test Plan:
- rst, then flags_we with Z=1,C=0,N=0,V=0; next cycle cond=0 (EQ) with cond_valid -> following cycle take=1, take_valid=1; cond=1 (NE) -> take=0.
- Load flags Z=0,C=1,N=1,V=0 (as after 0x0001-0x0002), then evaluate cond 9 (LS) -> take=1; cond 8 (HI) -> take=0; cond 11 (LT) -> take=1; cond 10 (GE) -> take=0.
- STACK_DEPTH=4: push 4 distinct flag values 0x1,0x2,0x4,0x8 -> depth=4, stk_full=1; 5th push -> depth=4, stk_err=1; 4 pops -> flags 0x8,0x4,0x2,0x1 in that order, stk_empty=1.
- Empty stack, pop with flags_we=1 and inputs 0xA -> flags=0xA, depth=0, stk_err=1.
- push+pop same cycle at depth=2 -> depth=2, flags unchanged, stk_err=1; then rst -> stk_err=0, depth=0, flags=0.
- flags=0 with flags_we=1 (Z=1) and cond=EQ in the same cycle -> take=0 without FLAG_FWD_EN, take=1 with it.
